// File: rtl/ekf_stage_issuer.sv
// rtl/ekf_stage_issuer.sv - Issues PRD/NEW/UPD stage commands to the EKF core and captures S_data.
// Optional macro STAGE_TIMEOUT_EN aborts a stalled stage once a TO_DW-bit wait counter saturates.

module ekf_stage_issuer #(
  parameter int RSA_DW  = 32,
  parameter int RSA_AW  = 17,
  parameter int ROW_LEN = 10,
  parameter int MAX_LM  = 16,
  parameter int TO_DW   = 16
) (
  input  logic               clk_i,
  input  logic               sys_rst_i,
  input  logic               cmd_val_i,
  output logic               cmd_rdy_o,
  input  logic [2:0]         cmd_stage_i,
  input  logic [ROW_LEN-1:0] cmd_lk_i,
  input  logic [RSA_DW-1:0]  cmd_vlr_i,
  input  logic [RSA_AW-1:0]  cmd_alpha_i,
  input  logic [RSA_DW-1:0]  cmd_rk_i,
  input  logic [RSA_AW-1:0]  cmd_phi_i,
  output logic [2:0]         stage_val_o,
  input  logic [2:0]         stage_rdy_i,
  output logic [ROW_LEN-1:0] landmark_num_o,
  output logic [ROW_LEN-1:0] l_k_o,
  output logic [RSA_DW-1:0]  vlr_o,
  output logic [RSA_AW-1:0]  alpha_o,
  output logic [RSA_DW-1:0]  rk_o,
  output logic [RSA_AW-1:0]  phi_o,
  input  logic [RSA_DW-1:0]  S_data_i,
  output logic               res_val_o,
  output logic [RSA_DW-1:0]  res_data_o,
  output logic [2:0]         res_stage_o,
  output logic               err_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_BUSY      = 3'd2,
    S_DONE_WAIT = 3'd3,
    S_REPORT    = 3'd4
  } state_t;

  localparam logic [2:0]         ST_PRD   = 3'b001;
  localparam logic [2:0]         ST_NEW   = 3'b010;
  localparam logic [2:0]         ST_UPD   = 3'b100;
  localparam logic [ROW_LEN-1:0] LM_MAX_V = ROW_LEN'(MAX_LM);
  localparam logic [ROW_LEN-1:0] LM_ONE   = ROW_LEN'(1);

  state_t               state_q, state_d;
  logic [2:0]           stage_q, stage_d;
  logic [ROW_LEN-1:0]   lk_q, lk_d;
  logic [ROW_LEN-1:0]   landmark_q, landmark_d;
  logic [RSA_DW-1:0]    vlr_q, vlr_d;
  logic [RSA_AW-1:0]    alpha_q, alpha_d;
  logic [RSA_DW-1:0]    rk_q, rk_d;
  logic [RSA_AW-1:0]    phi_q, phi_d;
  logic [RSA_DW-1:0]    res_data_q, res_data_d;
  logic [2:0]           res_stage_q, res_stage_d;
  logic                 err_q, err_d;
  logic                 busy_hold_q, busy_hold_d;

  logic accept;
  logic onehot;
  logic lm_full;
  logic cmd_ok;
  logic rdy_hit;
  logic timeout;

  assign accept  = cmd_val_i && (state_q == S_IDLE);
  assign onehot  = (cmd_stage_i == ST_PRD) || (cmd_stage_i == ST_NEW) || (cmd_stage_i == ST_UPD);
  assign lm_full = (landmark_q == LM_MAX_V);
  assign cmd_ok  = onehot && !((cmd_stage_i == ST_NEW) && lm_full);
  // Only the ready bit of the issued stage matters; the others belong to other stages.
  assign rdy_hit = |(stage_q & stage_rdy_i);

  always_ff @(posedge clk_i) begin
    if (sys_rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept && cmd_ok) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (rdy_hit) state_d = S_BUSY;
      end
      S_BUSY: begin
        // Ready still high two cycles after transfer: the core finished without dropping it.
        if (!rdy_hit) state_d = S_DONE_WAIT;
        else if (busy_hold_q) state_d = S_REPORT;
      end
      S_DONE_WAIT: begin
        if (rdy_hit) state_d = S_REPORT;
      end
      S_REPORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (timeout) state_d = S_IDLE;
  end

  always_comb begin
    cmd_rdy_o   = (state_q == S_IDLE);
    stage_val_o = (state_q == S_ISSUE) ? stage_q : 3'b000;
    res_val_o   = (state_q == S_REPORT);
  end

  always_comb begin
    stage_d     = stage_q;
    lk_d        = lk_q;
    vlr_d       = vlr_q;
    alpha_d     = alpha_q;
    rk_d        = rk_q;
    phi_d       = phi_q;
    landmark_d  = landmark_q;
    res_data_d  = res_data_q;
    res_stage_d = res_stage_q;
    err_d       = (accept && !cmd_ok) || timeout;
    busy_hold_d = (state_q == S_BUSY) && (state_d == S_BUSY);

    if (accept && cmd_ok) begin
      stage_d = cmd_stage_i;
      vlr_d   = cmd_vlr_i;
      alpha_d = cmd_alpha_i;
      rk_d    = cmd_rk_i;
      phi_d   = cmd_phi_i;
      case (cmd_stage_i)
        ST_NEW:  lk_d = landmark_q;
        ST_UPD:  lk_d = cmd_lk_i;
        default: lk_d = '0;
      endcase
    end

    if ((state_d == S_REPORT) && (state_q != S_REPORT)) begin
      res_data_d  = S_data_i;
      res_stage_d = stage_q;
    end

    if ((state_q == S_REPORT) && (stage_q == ST_NEW) && !lm_full) begin
      landmark_d = landmark_q + LM_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (sys_rst_i) begin
      stage_q     <= '0;
      lk_q        <= '0;
      vlr_q       <= '0;
      alpha_q     <= '0;
      rk_q        <= '0;
      phi_q       <= '0;
      landmark_q  <= '0;
      res_data_q  <= '0;
      res_stage_q <= '0;
      err_q       <= 1'b0;
      busy_hold_q <= 1'b0;
    end else begin
      stage_q     <= stage_d;
      lk_q        <= lk_d;
      vlr_q       <= vlr_d;
      alpha_q     <= alpha_d;
      rk_q        <= rk_d;
      phi_q       <= phi_d;
      landmark_q  <= landmark_d;
      res_data_q  <= res_data_d;
      res_stage_q <= res_stage_d;
      err_q       <= err_d;
      busy_hold_q <= busy_hold_d;
    end
  end

`ifdef STAGE_TIMEOUT_EN
  localparam logic [TO_DW-1:0] TO_ONE = TO_DW'(1);

  logic [TO_DW-1:0] to_cnt_q, to_cnt_d;
  logic             waiting;

  assign waiting = (state_q == S_ISSUE) || (state_q == S_BUSY) || (state_q == S_DONE_WAIT);
  assign timeout = waiting && (&to_cnt_q);

  // Restarts on every state change so each wait phase gets its own full budget.
  always_comb begin
    to_cnt_d = '0;
    if (waiting && (state_d == state_q)) to_cnt_d = to_cnt_q + TO_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (sys_rst_i) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign landmark_num_o = landmark_q;
  assign l_k_o          = lk_q;
  assign vlr_o          = vlr_q;
  assign alpha_o        = alpha_q;
  assign rk_o           = rk_q;
  assign phi_o          = phi_q;
  assign res_data_o     = res_data_q;
  assign res_stage_o    = res_stage_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_ekf_stage_issuer.sv
// tb/tb_ekf_stage_issuer.sv - Directed self-checking bench for ekf_stage_issuer.

module tb_ekf_stage_issuer;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        cmd_val;
  logic        cmd_rdy;
  logic [2:0]  cmd_stage;
  logic [9:0]  cmd_lk;
  logic [31:0] cmd_vlr;
  logic [16:0] cmd_alpha;
  logic [31:0] cmd_rk;
  logic [16:0] cmd_phi;
  logic [2:0]  stage_val;
  logic [2:0]  stage_rdy;
  logic [9:0]  landmark_num;
  logic [9:0]  l_k;
  logic [31:0] vlr;
  logic [16:0] alpha;
  logic [31:0] rk;
  logic [16:0] phi;
  logic [31:0] S_data;
  logic        res_val;
  logic [31:0] res_data;
  logic [2:0]  res_stage;
  logic        err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ekf_stage_issuer dut (
    .clk_i          (clk),
    .sys_rst_i      (sys_rst),
    .cmd_val_i      (cmd_val),
    .cmd_rdy_o      (cmd_rdy),
    .cmd_stage_i    (cmd_stage),
    .cmd_lk_i       (cmd_lk),
    .cmd_vlr_i      (cmd_vlr),
    .cmd_alpha_i    (cmd_alpha),
    .cmd_rk_i       (cmd_rk),
    .cmd_phi_i      (cmd_phi),
    .stage_val_o    (stage_val),
    .stage_rdy_i    (stage_rdy),
    .landmark_num_o (landmark_num),
    .l_k_o          (l_k),
    .vlr_o          (vlr),
    .alpha_o        (alpha),
    .rk_o           (rk),
    .phi_o          (phi),
    .S_data_i       (S_data),
    .res_val_o      (res_val),
    .res_data_o     (res_data),
    .res_stage_o    (res_stage),
    .err_o          (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [2:0] stg, input logic [9:0] lk, input logic [31:0] v,
                           input logic [16:0] a, input logic [31:0] r, input logic [16:0] p);
    cmd_stage = stg;
    cmd_lk    = lk;
    cmd_vlr   = v;
    cmd_alpha = a;
    cmd_rk    = r;
    cmd_phi   = p;
    cmd_val   = 1'b1;
    tick();
    cmd_val   = 1'b0;
  endtask

  task automatic run_new_instant();
    stage_rdy = 3'b010;
    issue_cmd(3'b010, 10'd0, 32'd1, 17'd1, 32'd1, 17'd1);
    repeat (4) tick();
  endtask

  task automatic test_reset();
    sys_rst   = 1'b1;
    cmd_val   = 1'b0;
    cmd_stage = 3'b000;
    cmd_lk    = '0;
    cmd_vlr   = '0;
    cmd_alpha = '0;
    cmd_rk    = '0;
    cmd_phi   = '0;
    stage_rdy = 3'b000;
    S_data    = '0;
    repeat (2) tick();
    sys_rst = 1'b0;
    tick();
    checks++;
    if (cmd_rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_cmd_rdy got=%0b exp=1", cmd_rdy);
    end
    checks++;
    if ({stage_val, landmark_num, l_k, vlr, alpha, rk, phi, res_val, res_data, res_stage, err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs_zero stage_val=%0h lm=%0d res_val=%0b err=%0b", stage_val, landmark_num, res_val, err);
    end
  endtask

  task automatic test_prd();
    stage_rdy = 3'b001;
    issue_cmd(3'b001, 10'd9, 32'd2, 17'd3, 32'd0, 17'd0);
    checks++;
    if (stage_val !== 3'b001 || cmd_rdy !== 1'b0) begin
      failures++;
      $display("FAIL prd_issue stage_val=%0b cmd_rdy=%0b exp 001/0", stage_val, cmd_rdy);
    end
    checks++;
    if (vlr !== 32'd2 || alpha !== 17'd3 || l_k !== 10'd0) begin
      failures++;
      $display("FAIL prd_operands vlr=%0d alpha=%0d l_k=%0d exp 2/3/0", vlr, alpha, l_k);
    end
    tick();
    checks++;
    if (stage_val !== 3'b000) begin
      failures++;
      $display("FAIL prd_stage_val_drop got=%0b exp=000", stage_val);
    end
    stage_rdy = 3'b000;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (res_val !== 1'b0 || stage_val !== 3'b000) begin
        failures++;
        $display("FAIL prd_wait_%0d res_val=%0b stage_val=%0b exp 0/000", i, res_val, stage_val);
      end
    end
    stage_rdy = 3'b001;
    S_data    = 32'h55;
    tick();
    checks++;
    if (res_val !== 1'b1 || res_data !== 32'h55 || res_stage !== 3'b001) begin
      failures++;
      $display("FAIL prd_report res_val=%0b res_data=%0h res_stage=%0b exp 1/55/001", res_val, res_data, res_stage);
    end
    tick();
    checks++;
    if (res_val !== 1'b0 || cmd_rdy !== 1'b1 || landmark_num !== 10'd0) begin
      failures++;
      $display("FAIL prd_after res_val=%0b cmd_rdy=%0b lm=%0d exp 0/1/0", res_val, cmd_rdy, landmark_num);
    end
  endtask

  task automatic test_new();
    for (int i = 0; i < 2; i++) begin
      stage_rdy = 3'b010;
      issue_cmd(3'b010, 10'd7, 32'd0, 17'd0, 32'd4, 17'd5);
      checks++;
      if (stage_val !== 3'b010 || l_k !== 10'(i) || rk !== 32'd4 || phi !== 17'd5) begin
        failures++;
        $display("FAIL new%0d_issue stage_val=%0b l_k=%0d rk=%0d phi=%0d exp 010/%0d/4/5", i, stage_val, l_k, rk, phi, i);
      end
      tick();
      stage_rdy = 3'b000;
      repeat (3) tick();
      stage_rdy = 3'b010;
      S_data    = 32'hA0 + 32'(i);
      tick();
      checks++;
      if (res_val !== 1'b1 || res_stage !== 3'b010 || res_data !== 32'hA0 + 32'(i) ||
          l_k !== 10'(i) || landmark_num !== 10'(i)) begin
        failures++;
        $display("FAIL new%0d_report res_val=%0b res_stage=%0b res_data=%0h l_k=%0d lm=%0d", i, res_val, res_stage, res_data, l_k, landmark_num);
      end
      tick();
      checks++;
      if (landmark_num !== 10'(i + 1)) begin
        failures++;
        $display("FAIL new%0d_landmark got=%0d exp=%0d", i, landmark_num, i + 1);
      end
    end
  endtask

  task automatic test_upd();
    stage_rdy = 3'b011;
    issue_cmd(3'b100, 10'd2, 32'd11, 17'd12, 32'd13, 17'd14);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (stage_val !== 3'b100 || l_k !== 10'd2 || vlr !== 32'd11 || alpha !== 17'd12 ||
          rk !== 32'd13 || phi !== 17'd14) begin
        failures++;
        $display("FAIL upd_hold_%0d stage_val=%0b l_k=%0d vlr=%0d alpha=%0d rk=%0d phi=%0d", i, stage_val, l_k, vlr, alpha, rk, phi);
      end
      if (i < 5) tick();
    end
    stage_rdy = 3'b100;
    tick();
    checks++;
    if (stage_val !== 3'b000) begin
      failures++;
      $display("FAIL upd_transfer stage_val=%0b exp=000", stage_val);
    end
    stage_rdy = 3'b000;
    tick();
    stage_rdy = 3'b100;
    S_data    = 32'h1234;
    tick();
    checks++;
    if (res_val !== 1'b1 || res_data !== 32'h1234 || res_stage !== 3'b100 || landmark_num !== 10'd2) begin
      failures++;
      $display("FAIL upd_report res_val=%0b res_data=%0h res_stage=%0b lm=%0d", res_val, res_data, res_stage, landmark_num);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    stage_rdy = 3'b001;
    S_data    = 32'h77;
    issue_cmd(3'b001, 10'd0, 32'd5, 17'd6, 32'd0, 17'd0);
    tick();
    tick();
    checks++;
    if (res_val !== 1'b0) begin
      failures++;
      $display("FAIL instant_early res_val=%0b exp=0", res_val);
    end
    tick();
    checks++;
    if (res_val !== 1'b1 || res_data !== 32'h77 || res_stage !== 3'b001) begin
      failures++;
      $display("FAIL instant_report res_val=%0b res_data=%0h res_stage=%0b exp 1/77/001", res_val, res_data, res_stage);
    end
    tick();
    stage_rdy = 3'b100;
    S_data    = 32'h88;
    issue_cmd(3'b100, 10'd5, 32'd8, 17'd9, 32'd0, 17'd0);
    checks++;
    if (stage_val !== 3'b100 || l_k !== 10'd5 || vlr !== 32'd8) begin
      failures++;
      $display("FAIL b2b_issue stage_val=%0b l_k=%0d vlr=%0d exp 100/5/8", stage_val, l_k, vlr);
    end
    repeat (3) tick();
    checks++;
    if (res_val !== 1'b1 || res_data !== 32'h88 || res_stage !== 3'b100) begin
      failures++;
      $display("FAIL b2b_report res_val=%0b res_data=%0h res_stage=%0b exp 1/88/100", res_val, res_data, res_stage);
    end
    tick();
  endtask

  task automatic test_reject();
    stage_rdy = 3'b000;
    issue_cmd(3'b011, 10'd0, 32'd0, 17'd0, 32'd0, 17'd0);
    checks++;
    if (err !== 1'b1 || stage_val !== 3'b000 || cmd_rdy !== 1'b1) begin
      failures++;
      $display("FAIL rej_onehot err=%0b stage_val=%0b cmd_rdy=%0b exp 1/000/1", err, stage_val, cmd_rdy);
    end
    tick();
    checks++;
    if (err !== 1'b0 || stage_val !== 3'b000 || landmark_num !== 10'd2) begin
      failures++;
      $display("FAIL rej_onehot_after err=%0b stage_val=%0b lm=%0d exp 0/000/2", err, stage_val, landmark_num);
    end
    for (int i = 0; i < 14; i++) run_new_instant();
    checks++;
    if (landmark_num !== 10'd16) begin
      failures++;
      $display("FAIL rej_fill lm=%0d exp=16", landmark_num);
    end
    stage_rdy = 3'b010;
    issue_cmd(3'b010, 10'd0, 32'd0, 17'd0, 32'd0, 17'd0);
    checks++;
    if (err !== 1'b1 || stage_val !== 3'b000) begin
      failures++;
      $display("FAIL rej_full err=%0b stage_val=%0b exp 1/000", err, stage_val);
    end
    tick();
    checks++;
    if (err !== 1'b0 || stage_val !== 3'b000 || landmark_num !== 10'd16 || res_val !== 1'b0) begin
      failures++;
      $display("FAIL rej_full_after err=%0b stage_val=%0b lm=%0d res_val=%0b exp 0/000/16/0", err, stage_val, landmark_num, res_val);
    end
  endtask

  task automatic test_reset_mid();
    stage_rdy = 3'b001;
    issue_cmd(3'b001, 10'd0, 32'd9, 17'd4, 32'd3, 17'd2);
    tick();
    stage_rdy = 3'b000;
    repeat (2) tick();
    checks++;
    if (cmd_rdy !== 1'b0 || stage_val !== 3'b000 || vlr !== 32'd9) begin
      failures++;
      $display("FAIL rstmid_pre cmd_rdy=%0b stage_val=%0b vlr=%0d exp 0/000/9", cmd_rdy, stage_val, vlr);
    end
    sys_rst = 1'b1;
    tick();
    checks++;
    if (cmd_rdy !== 1'b1 ||
        {stage_val, landmark_num, l_k, vlr, alpha, rk, phi, res_val, res_data, res_stage, err} !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs cmd_rdy=%0b lm=%0d vlr=%0d res_val=%0b res_data=%0h", cmd_rdy, landmark_num, vlr, res_val, res_data);
    end
    sys_rst   = 1'b0;
    stage_rdy = 3'b001;
    S_data    = 32'h99;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (res_val !== 1'b0 || cmd_rdy !== 1'b1 || res_data !== 32'h0) begin
        failures++;
        $display("FAIL rstmid_after_%0d res_val=%0b cmd_rdy=%0b res_data=%0h exp 0/1/0", i, res_val, cmd_rdy, res_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_prd();
    test_new();
    test_upd();
    test_back_to_back();
    test_reject();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ekf_stage_issuer.md
Name: ekf_stage_issuer

Overview:
- Initiator-side sequencer for the EKF core's stage handshake. It drives `stage_val` and the measurement operands, and observes `stage_rdy`.
- Accepts a stream of stage commands (PRD / NEW / UPD) from the host. It issues one command at a time, holds the operands stable until the core finishes, and captures `S_data` at completion.
- Owns the landmark count: `landmark_num` and `l_k` for NEW stages.
- Sits between the host/measurement front-end and the core top.

Parameters:
- RSA_DW, 32, operand/result data width (`vlr`, `rk`, `S_data`).
- RSA_AW, 17, angle operand width (`alpha`, `phi`).
- ROW_LEN, 10, landmark index/count width.
- MAX_LM, 16, maximum landmark count; a NEW is refused once the count reaches this value.
- TO_DW, 16, timeout counter width (used only with the optional feature).

Ports:
- clk  in  1  clock
- sys_rst  in  1  synchronous active-high reset
- cmd_val  in  1  host command valid
- cmd_rdy  out  1  issuer can accept a command
- cmd_stage  in  3  one-hot stage code: 001 PRD, 010 NEW, 100 UPD
- cmd_lk  in  ROW_LEN  landmark index (UPD only)
- cmd_vlr  in  RSA_DW  velocity operand
- cmd_alpha  in  RSA_AW  steering operand
- cmd_rk  in  RSA_DW  range operand
- cmd_phi  in  RSA_AW  bearing operand
- stage_val  out  3  one-hot stage request to core
- stage_rdy  in  3  per-stage core ready
- landmark_num  out  ROW_LEN  current landmark count
- l_k  out  ROW_LEN  landmark index for current stage
- vlr  out  RSA_DW  held operand
- alpha  out  RSA_AW  held operand
- rk  out  RSA_DW  held operand
- phi  out  RSA_AW  held operand
- S_data  in  RSA_DW  core result
- res_val  out  1  one-cycle result strobe
- res_data  out  RSA_DW  captured `S_data`
- res_stage  out  3  stage that produced `res_data`
- err  out  1  one-cycle strobe: command rejected

Behaviour:
- Reset:
  - All outputs are 0 except `cmd_rdy`=1.
  - `landmark_num` = 0; FSM = IDLE.
  - Reset mid-stage aborts immediately and drops the pending result.
- IDLE: `cmd_rdy`=1. A command is accepted on `cmd_val & cmd_rdy`.
- Command rejection:
  - A command is rejected if `cmd_stage` is not exactly one-hot, or if it is NEW while `landmark_num` == MAX_LM.
  - Rejection pulses `err` for 1 cycle in the cycle after acceptance; the FSM stays in IDLE and nothing is issued.
- Valid command:
  - Registers `vlr`, `alpha`, `rk` and `phi`.
  - `l_k` = `landmark_num` for NEW, `cmd_lk` for UPD, and 0 for PRD.
  - Moves to ISSUE. `cmd_rdy`=0 in every state except IDLE.
- ISSUE:
  - `stage_val` = the registered one-hot code, held until `stage_val & stage_rdy` is non-zero (transfer).
  - On transfer, `stage_val` drops to 0 on the next cycle and the FSM goes to BUSY.
- BUSY:
  - Wait until the accepted `stage_rdy` bit is 0, then go to DONE_WAIT.
  - If that bit is still 1 two cycles after transfer, the core is treated as having completed instantly; go straight to REPORT.
- DONE_WAIT: wait for the accepted `stage_rdy` bit to return to 1, then go to REPORT.
- REPORT (one cycle):
  - `res_data` <= `S_data` and `res_stage` <= the stage code.
  - `res_val`=1 for exactly this cycle.
  - For NEW only, `landmark_num` increments by 1 (saturating at MAX_LM).
  - Returns to IDLE.
- Operand stability: `l_k`, `vlr`, `alpha`, `rk` and `phi` are constant from ISSUE entry through REPORT. `landmark_num` changes only in REPORT.
- Latency:
  - Accept to `stage_val` high: 1 cycle.
  - Core completion (`stage_rdy` rising) to `res_val`: 1 cycle.
  - Back-to-back commands are separated by at least 1 IDLE cycle.
- `stage_rdy` bits not matching the issued stage are ignored.

Optional Feature:
- Macro: `STAGE_TIMEOUT_EN`.
- When defined:
  - A TO_DW-bit counter runs during ISSUE, BUSY and DONE_WAIT and clears on each state change.
  - When it saturates, `err` pulses, `stage_val` drops, and no `res_val` is produced.
  - `landmark_num` is unchanged and the FSM returns to IDLE.
- When undefined: there is no counter, and the issuer waits indefinitely.

Test Plan:
- PRD, `vlr`=2, `alpha`=3; core holds `stage_rdy`[0]=1, drops it for 20 cycles, then raises it with `S_data`=0x55 → `stage_val`=001 for 1+ cycles; `res_val` pulses 1 cycle after the rise; `res_data`=0x55, `res_stage`=001.
- NEW with `rk`=4, `phi`=5 at reset → `l_k`=0 held through the stage; after REPORT `landmark_num`=1. A second NEW gives `l_k`=1 and `landmark_num`=2.
- UPD with `cmd_lk`=2 while `stage_rdy`[2]=0 for 5 cycles → `stage_val`=100 held 5+ cycles with operands stable; transfer occurs when `stage_rdy`[2] goes to 1.
- `cmd_stage`=011, then a NEW with `landmark_num`=MAX_LM=16 → each produces one `err` pulse, `stage_val` stays 0, and `landmark_num` stays 16.
- `sys_rst` asserted in DONE_WAIT → next cycle all outputs are 0, `cmd_rdy`=1, `landmark_num`=0, and no `res_val`.
- With `STAGE_TIMEOUT_EN` and TO_DW=4, core never re-raises `stage_rdy` → `err` pulses after 15 cycles in DONE_WAIT; return to IDLE; `landmark_num` unchanged.
